// File: rtl/serialparalelo_align.sv
// Serial-to-parallel receiver with comma-based word alignment.
// Finds the word boundary at any bit offset, locks after LOCK_COUNT aligned commas, re-aligns after LOSS_COUNT misaligned ones.
module serialparalelo_align #(
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  COMMA      = 8'hBC,
  parameter int                LOCK_COUNT = 4,
  parameter int                LOSS_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             comma_out,
  output logic             active_out,
  output logic [1:0]       state_out
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SYNC  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [PW-1:0]    r_phase;
  logic [3:0]       r_lock_cnt;
  logic [3:0]       r_miss_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_comma;
  logic             r_active;

  state_t           w_state_nxt;
  logic [PW-1:0]    w_phase_nxt;
  logic [3:0]       w_lock_nxt;
  logic [3:0]       w_miss_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_comma_nxt;

  logic [WIDTH-1:0] w_word_next;
  logic             w_boundary;
  logic             w_is_comma;
  logic [3:0]       w_lock_inc;
  logic [3:0]       w_miss_inc;
  state_t           w_lock_target;

  // The word including the bit being sampled now drives every comparison.
  assign w_word_next   = {r_sr[WIDTH-2:0], serial_in};
  assign w_boundary    = (r_phase == PW'(WIDTH - 1));
  assign w_is_comma    = (w_word_next == COMMA);
  assign w_lock_inc    = r_lock_cnt + 4'd1;
  assign w_miss_inc    = r_miss_cnt + 4'd1;
  assign w_lock_target = (LOCK_COUNT == 1) ? ST_SYNC : ST_CHECK;

  // Next-state, alignment counters and output strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = w_boundary ? '0 : (r_phase + PW'(1));
    w_lock_nxt  = r_lock_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_comma_nxt = 1'b0;

    case (r_state)
      ST_HUNT: begin
        if (w_is_comma) begin
          w_phase_nxt = '0;
          w_lock_nxt  = 4'd1;
          w_state_nxt = w_lock_target;
        end else begin
          w_lock_nxt  = 4'd0;
        end
      end

      ST_CHECK: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_lock_nxt = w_lock_inc;
            if (w_lock_inc >= 4'(LOCK_COUNT)) begin
              w_state_nxt = ST_SYNC;
              w_miss_nxt  = 4'd0;
            end else begin
              w_state_nxt = ST_CHECK;
            end
          end else begin
            w_state_nxt = ST_HUNT;
            w_lock_nxt  = 4'd0;
          end
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end

      ST_SYNC: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_comma_nxt = 1'b1;
            w_miss_nxt  = 4'd0;
          end else begin
            w_data_nxt  = w_word_next;
            w_valid_nxt = 1'b1;
          end
        end else if (w_is_comma) begin
          // The misaligned comma that trips the loss limit seeds the new lock.
          if (w_miss_inc >= 4'(LOSS_COUNT)) begin
            w_phase_nxt = '0;
            w_lock_nxt  = 4'd1;
            w_miss_nxt  = 4'd0;
            w_state_nxt = w_lock_target;
          end else begin
            w_miss_nxt  = w_miss_inc;
          end
        end else begin
          w_miss_nxt = r_miss_cnt;
        end
      end

      default: begin
        w_state_nxt = ST_HUNT;
        w_phase_nxt = '0;
        w_lock_nxt  = 4'd0;
        w_miss_nxt  = 4'd0;
      end
    endcase
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_HUNT;
      r_sr       <= '0;
      r_phase    <= '0;
      r_lock_cnt <= 4'd0;
      r_miss_cnt <= 4'd0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_comma    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sr       <= w_word_next;
      r_phase    <= w_phase_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_comma    <= w_comma_nxt;
      r_active   <= (w_state_nxt == ST_SYNC);
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign comma_out  = r_comma;
  assign active_out = r_active;
  assign state_out  = r_state;

endmodule

// File: tb/tb_serialparalelo_align.sv
// Scoreboard bench for serialparalelo_align: an 8-bit default instance and a 10-bit, LOCK_COUNT=2 instance.
module tb_serialparalelo_align;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin_a = 1'b0;
  logic       sin_b = 1'b0;

  logic [7:0] data_a;
  logic       valid_a, comma_a, active_a;
  logic [1:0] state_a;
  logic [9:0] data_b;
  logic       valid_b, comma_b, active_b;
  logic [1:0] state_b;

  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] pop_a, pop_b;

  always #5 clk = ~clk;

  serialparalelo_align u_dut_a (
    .clk_32f   (clk),
    .reset     (rst_n),
    .serial_in (sin_a),
    .data_out  (data_a),
    .valid_out (valid_a),
    .comma_out (comma_a),
    .active_out(active_a),
    .state_out (state_a)
  );

  serialparalelo_align #(
    .WIDTH     (10),
    .COMMA     (10'h17C),
    .LOCK_COUNT(2),
    .LOSS_COUNT(4)
  ) u_dut_b (
    .clk_32f   (clk),
    .reset     (rst_n),
    .serial_in (sin_b),
    .data_out  (data_b),
    .valid_out (valid_b),
    .comma_out (comma_b),
    .active_out(active_b),
    .state_out (state_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit before the rising edge, return just after it has been sampled.
  task automatic send_bit(input logic b, input bit to_b);
    @(negedge clk);
    if (to_b) sin_b = b;
    else      sin_a = b;
    @(posedge clk);
    #1;
  endtask

  // Send the low n bits of w, MSB first.
  task automatic send_word(input logic [15:0] w, input int n, input bit to_b);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], to_b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sin_a = 1'b0;
    sin_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_valid", {24'd0, data_a}, 32'hFFFF_FFFF);
      end else begin
        pop_a = exp_a.pop_front();
        check("a_data", {24'd0, data_a}, {22'd0, pop_a});
        check("a_comma_with_valid", {31'd0, comma_a}, 32'd0);
        check("a_active_with_valid", {31'd0, active_a}, 32'd1);
      end
    end
  end

  // Monitor for the 10-bit instance.
  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_valid", {22'd0, data_b}, 32'hFFFF_FFFF);
      end else begin
        pop_b = exp_b.pop_front();
        check("b_data", {22'd0, data_b}, {22'd0, pop_b});
        check("b_comma_with_valid", {31'd0, comma_b}, 32'd0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_a",   {24'd0, data_a},   32'd0);
    check("rst_valid_a",  {31'd0, valid_a},  32'd0);
    check("rst_comma_a",  {31'd0, comma_a},  32'd0);
    check("rst_active_a", {31'd0, active_a}, 32'd0);
    check("rst_state_a",  {30'd0, state_a},  32'd0);
    check("rst_state_b",  {30'd0, state_b},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned lock, two data words, then an idle comma.
    send_word(16'hBC, 8, 1'b0);
    check("t1_check_after_1st", {30'd0, state_a}, 32'd1);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    check("t1_state_after_3rd", {30'd0, state_a}, 32'd1);
    check("t1_active_after_3rd", {31'd0, active_a}, 32'd0);
    send_word(16'hBC, 8, 1'b0);
    check("t1_sync_after_4th", {30'd0, state_a}, 32'd2);
    check("t1_active_after_4th", {31'd0, active_a}, 32'd1);
    exp_a.push_back(10'h05A);
    send_word(16'h5A, 8, 1'b0);
    check("t1_valid_5a", {31'd0, valid_a}, 32'd1);
    exp_a.push_back(10'h03C);
    send_bit(1'b0, 1'b0);
    check("t1_valid_one_cycle", {31'd0, valid_a}, 32'd0);
    send_word(16'h3C, 7, 1'b0);
    check("t1_valid_3c", {31'd0, valid_a}, 32'd1);
    send_word(16'hBC, 8, 1'b0);
    check("t1_comma_strobe", {31'd0, comma_a}, 32'd1);
    check("t1_comma_no_valid", {31'd0, valid_a}, 32'd0);
    check("t1_data_held", {24'd0, data_a}, 32'h3C);

    // Lock at a 3-bit offset.
    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t2_hunt_after_junk", {30'd0, state_a}, 32'd0);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    check("t2_check_after_3", {30'd0, state_a}, 32'd1);
    send_word(16'hBC, 8, 1'b0);
    check("t2_sync_after_4", {30'd0, state_a}, 32'd2);
    exp_a.push_back(10'h0A5);
    send_word(16'hA5, 8, 1'b0);
    check("t2_valid_a5", {31'd0, valid_a}, 32'd1);

    // CHECK aborted by a non-comma boundary word; lock count must restart.
    do_reset();
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    check("t3_check", {30'd0, state_a}, 32'd1);
    send_word(16'h00, 8, 1'b0);
    check("t3_back_to_hunt", {30'd0, state_a}, 32'd0);
    check("t3_active_low", {31'd0, active_a}, 32'd0);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    check("t3_still_check", {30'd0, state_a}, 32'd1);
    send_word(16'hBC, 8, 1'b0);
    check("t3_relocked", {30'd0, state_a}, 32'd2);

    // One slipped bit: every shifted comma lands one bit after the boundary word 0x5E.
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_a.push_back(10'h05E);
      send_word(16'hBC, 8, 1'b0);
    end
    check("t4_sync_after_3_miss", {30'd0, state_a}, 32'd2);
    check("t4_active_after_3_miss", {31'd0, active_a}, 32'd1);
    exp_a.push_back(10'h05E);
    send_word(16'hBC, 8, 1'b0);
    check("t4_check_after_4_miss", {30'd0, state_a}, 32'd1);
    check("t4_active_dropped", {31'd0, active_a}, 32'd0);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    check("t4_check_before_relock", {30'd0, state_a}, 32'd1);
    send_word(16'hBC, 8, 1'b0);
    check("t4_relock_new_phase", {30'd0, state_a}, 32'd2);
    exp_a.push_back(10'h066);
    send_word(16'h66, 8, 1'b0);
    check("t4_valid_66", {31'd0, valid_a}, 32'd1);

    // Asynchronous reset mid-word while locked.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_async_data", {24'd0, data_a}, 32'd0);
    check("t5_async_active", {31'd0, active_a}, 32'd0);
    check("t5_async_state", {30'd0, state_a}, 32'd0);
    check("t5_async_valid", {31'd0, valid_a}, 32'd0);
    check("t5_async_comma", {31'd0, comma_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    send_word(16'hBC, 8, 1'b0);
    check("t5_check_after_3", {30'd0, state_a}, 32'd1);
    send_word(16'hBC, 8, 1'b0);
    check("t5_sync_after_4", {30'd0, state_a}, 32'd2);
    exp_a.push_back(10'h081);
    send_word(16'h81, 8, 1'b0);
    check("t5_valid_81", {31'd0, valid_a}, 32'd1);

    // 10-bit instance, LOCK_COUNT=2.
    do_reset();
    send_word(16'h017C, 10, 1'b1);
    check("t6_check_after_1", {30'd0, state_b}, 32'd1);
    send_word(16'h017C, 10, 1'b1);
    check("t6_sync_after_2", {30'd0, state_b}, 32'd2);
    check("t6_active", {31'd0, active_b}, 32'd1);
    exp_b.push_back(10'h2A5);
    send_word(16'h02A5, 10, 1'b1);
    check("t6_valid_2a5", {31'd0, valid_b}, 32'd1);
    exp_b.push_back(10'h0F3);
    send_word(16'h00F3, 10, 1'b1);
    check("t6_valid_0f3", {31'd0, valid_b}, 32'd1);
    check("t6_a_idle", {30'd0, state_a}, 32'd0);

    repeat (3) @(negedge clk);
    #1;
    check("a_words_outstanding", exp_a.size(), 32'd0);
    check("b_words_outstanding", exp_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
